// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampled UART receiver with majority vote, parity/stop checks and valid/ready output
module uart_rx_os #(
    parameter int BAUD_RATE   = 115200,
    parameter int CLOCK_FREQ  = 10000000,
    parameter int NB_DATA_OUT = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0
) (
    input  logic                   clock,
    input  logic                   i_reset_n,
    input  logic                   i_data,
    output logic [NB_DATA_OUT-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_frame_err,
    output logic                   o_parity_err,
    output logic                   o_overrun,
    output logic                   o_busy
);
    localparam int CLKS_PER_BIT = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int MID          = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int IW           = (NB_DATA_OUT > 1) ? $clog2(NB_DATA_OUT) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NB_DATA_OUT - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK
    } state_t;

    state_t                 state;
    logic                   sync1, sync2;
    logic [1:0]             hist;
    logic [1:0]             prime;
    logic                   armed;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [NB_DATA_OUT-1:0] shreg;
    logic                   par_err;
    logic                   deliver;

    // Voting window: synced line at counts MID-1, MID and MID+1 when cnt == MID+1.
    logic [2:0] window;
    logic       vote;
    logic       start_edge;

    assign window     = {hist, sync2};
    assign vote       = (window[0] & window[1]) | (window[0] & window[2]) | (window[1] & window[2]);
    assign start_edge = armed & hist[0] & ~sync2;
    assign o_busy     = (state != IDLE);

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1        <= 1'b1;
            sync2        <= 1'b1;
            hist         <= 2'b11;
            prime        <= 2'd0;
            armed        <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            par_err      <= 1'b0;
            deliver      <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            sync1 <= i_data;
            sync2 <= sync1;
            hist  <= {hist[0], sync2};

            // The preset sync flops must flush before a real high line can arm start detection.
            if (prime != 2'd2)
                prime <= prime + 2'd1;
            else if (sync2)
                armed <= 1'b1;

            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
            deliver      <= 1'b0;
            cnt          <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    par_err <= 1'b0;
                    if (cnt == CNT_DEC && vote) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= DATA;
                        idx   <= '0;
                    end
                end
                DATA: begin
                    if (cnt == CNT_DEC)
                        shreg[idx] <= vote;
                    if (cnt == CNT_LAST) begin
                        if (idx == IDX_LAST)
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        else
                            idx <= idx + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == CNT_DEC)
                        par_err <= vote ^ (^shreg) ^ ODD;
                    if (cnt == CNT_LAST)
                        state <= STOP;
                end
                STOP: begin
                    if (cnt == CNT_DEC) begin
                        cnt <= '0;
                        if (!vote) begin
                            o_frame_err <= 1'b1;
                            state       <= BREAK;
                        end else if (par_err) begin
                            o_parity_err <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            deliver <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                BREAK: begin
                    if (!sync2)
                        cnt <= '0;
                    else if (cnt == CNT_LAST)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A consumer taking the old word in the same cycle makes room for the new one.
            if (deliver) begin
                if (o_valid && !i_ready) begin
                    o_overrun <= 1'b1;
                end else begin
                    o_data  <= shreg;
                    o_valid <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed self-checking bench for uart_rx_os (8N1 and 8E1 instances)
module tb_uart_rx_os;
    localparam int BIT = 87;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line_a = 1'b1, line_b = 1'b1;
    logic       ready_a = 1'b1, ready_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b, busy_a, busy_b;

    int checks = 0;
    int failures = 0;

    always #50 clk = ~clk;

    uart_rx_os u_a (
        .clock(clk), .i_reset_n(rst_n), .i_data(line_a), .o_data(data_a), .o_valid(valid_a),
        .i_ready(ready_a), .o_frame_err(fe_a), .o_parity_err(pe_a), .o_overrun(ov_a), .o_busy(busy_a)
    );

    uart_rx_os #(.PARITY_EN(1), .PARITY_ODD(0)) u_b (
        .clock(clk), .i_reset_n(rst_n), .i_data(line_b), .o_data(data_b), .o_valid(valid_b),
        .i_ready(ready_b), .o_frame_err(fe_b), .o_parity_err(pe_b), .o_overrun(ov_b), .o_busy(busy_b)
    );

    logic [7:0] words_a[$];
    logic [7:0] words_b[$];
    int vcyc_a = 0, fe_cnt_a = 0, pe_cnt_a = 0, ov_cnt_a = 0;
    int fe_cnt_b = 0, pe_cnt_b = 0, ov_cnt_b = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_a) vcyc_a++;
            if (valid_a && ready_a) words_a.push_back(data_a);
            if (fe_a) fe_cnt_a++;
            if (pe_a) pe_cnt_a++;
            if (ov_a) ov_cnt_a++;
            if (valid_b && ready_b) words_b.push_back(data_b);
            if (fe_b) fe_cnt_b++;
            if (pe_b) pe_cnt_b++;
            if (ov_b) ov_cnt_b++;
        end
    end

    function automatic logic [11:0] frame8(input logic [7:0] d);
        return {3'b001, d, 1'b0};
    endfunction

    function automatic logic [11:0] frame8p(input logic [7:0] d, input logic p, input logic stop);
        return {1'b0, stop, p, d, 1'b0};
    endfunction

    function automatic logic [7:0] word_at(input bit sel, input int i);
        if (sel) return (words_b.size() > i) ? words_b[i] : 8'hxx;
        return (words_a.size() > i) ? words_a[i] : 8'hxx;
    endfunction

    task automatic send_bits(input bit sel, input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) line_b = bits[i];
            else     line_a = bits[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({data_a, valid_a, fe_a, pe_a, ov_a, busy_a} !== 13'd0) begin
            failures++;
            $display("FAIL reset_a: got %h required 0", {data_a, valid_a, fe_a, pe_a, ov_a, busy_a});
        end
        checks++;
        if ({data_b, valid_b, fe_b, pe_b, ov_b, busy_b} !== 13'd0) begin
            failures++;
            $display("FAIL reset_b: got %h required 0", {data_b, valid_b, fe_b, pe_b, ov_b, busy_b});
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_single();
        int n0 = words_a.size();
        int v0 = vcyc_a;
        int e0 = fe_cnt_a + pe_cnt_a + ov_cnt_a;
        send_bits(0, frame8(8'h3F), 10);
        checks++;
        if (busy_a !== 1'b0) begin
            failures++; $display("FAIL single_busy: got %b required 0", busy_a);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (words_a.size() - n0 != 1) begin
            failures++; $display("FAIL single_count: got %0d required 1", words_a.size() - n0);
        end
        checks++;
        if (word_at(0, n0) !== 8'h3F) begin
            failures++; $display("FAIL single_data: got %h required 3f", word_at(0, n0));
        end
        checks++;
        if (vcyc_a - v0 != 1) begin
            failures++; $display("FAIL single_valid_len: got %0d required 1", vcyc_a - v0);
        end
        checks++;
        if (fe_cnt_a + pe_cnt_a + ov_cnt_a - e0 != 0) begin
            failures++; $display("FAIL single_errs: got %0d required 0", fe_cnt_a + pe_cnt_a + ov_cnt_a - e0);
        end
    endtask

    task automatic test_back_to_back();
        int n0 = words_a.size();
        send_bits(0, frame8(8'hA5), 10);
        send_bits(0, frame8(8'h5A), 10);
        repeat (20) @(negedge clk);
        checks++;
        if (words_a.size() - n0 != 2) begin
            failures++; $display("FAIL b2b_count: got %0d required 2", words_a.size() - n0);
        end
        checks++;
        if (word_at(0, n0) !== 8'hA5) begin
            failures++; $display("FAIL b2b_first: got %h required a5", word_at(0, n0));
        end
        checks++;
        if (word_at(0, n0 + 1) !== 8'h5A) begin
            failures++; $display("FAIL b2b_second: got %h required 5a", word_at(0, n0 + 1));
        end
    endtask

    task automatic test_glitch();
        int n0 = words_a.size();
        int e0 = fe_cnt_a + pe_cnt_a + ov_cnt_a;
        int waited = 0;
        line_a = 1'b0;
        repeat (20) @(negedge clk);
        line_a = 1'b1;
        while (busy_a !== 1'b0 && waited < 45) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++; $display("FAIL glitch_idle: busy=%b after %0d clocks required 0", busy_a, waited);
        end
        repeat (100) @(negedge clk);
        checks++;
        if ((words_a.size() - n0) + (fe_cnt_a + pe_cnt_a + ov_cnt_a - e0) != 0) begin
            failures++;
            $display("FAIL glitch_quiet: words=%0d errs=%0d required 0", words_a.size() - n0,
                     fe_cnt_a + pe_cnt_a + ov_cnt_a - e0);
        end
    endtask

    task automatic test_frame_error();
        int n0 = words_a.size();
        int f0 = fe_cnt_a;
        send_bits(0, {3'b000, 8'hE4, 1'b0}, 10);
        line_a = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        line_a = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        send_bits(0, frame8(8'h3F), 10);
        repeat (20) @(negedge clk);
        checks++;
        if (fe_cnt_a - f0 != 1) begin
            failures++; $display("FAIL ferr_pulses: got %0d required 1", fe_cnt_a - f0);
        end
        checks++;
        if (words_a.size() - n0 != 1) begin
            failures++; $display("FAIL ferr_count: got %0d required 1", words_a.size() - n0);
        end
        checks++;
        if (word_at(0, n0) !== 8'h3F) begin
            failures++; $display("FAIL ferr_next: got %h required 3f", word_at(0, n0));
        end
    endtask

    task automatic test_overrun();
        int n0 = words_a.size();
        int o0 = ov_cnt_a;
        @(posedge clk); #1 ready_a = 1'b0;
        @(negedge clk);
        send_bits(0, frame8(8'h11), 10);
        send_bits(0, frame8(8'h22), 10);
        repeat (100) @(negedge clk);
        checks++;
        if (data_a !== 8'h11 || valid_a !== 1'b1) begin
            failures++; $display("FAIL ovr_hold: data=%h valid=%b required 11/1", data_a, valid_a);
        end
        checks++;
        if (ov_cnt_a - o0 != 1) begin
            failures++; $display("FAIL ovr_pulses: got %0d required 1", ov_cnt_a - o0);
        end
        checks++;
        if (words_a.size() - n0 != 0) begin
            failures++; $display("FAIL ovr_early: got %0d words required 0", words_a.size() - n0);
        end
        @(posedge clk); #1 ready_a = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (words_a.size() - n0 != 1 || word_at(0, n0) !== 8'h11) begin
            failures++;
            $display("FAIL ovr_consume: count=%0d word=%h required 1/11", words_a.size() - n0, word_at(0, n0));
        end
        checks++;
        if (valid_a !== 1'b0) begin
            failures++; $display("FAIL ovr_valid_clear: got %b required 0", valid_a);
        end
    endtask

    task automatic test_parity_and_reset();
        int n0 = words_b.size();
        int p0 = pe_cnt_b;
        bit stayed_idle = 1'b1;
        send_bits(1, frame8p(8'h07, 1'b1, 1'b1), 11);
        repeat (20) @(negedge clk);
        checks++;
        if (words_b.size() - n0 != 1 || word_at(1, n0) !== 8'h07 || pe_cnt_b != p0) begin
            failures++;
            $display("FAIL par_good: count=%0d word=%h perr=%0d required 1/07/0", words_b.size() - n0,
                     word_at(1, n0), pe_cnt_b - p0);
        end
        send_bits(1, frame8p(8'h07, 1'b0, 1'b1), 11);
        repeat (20) @(negedge clk);
        checks++;
        if (pe_cnt_b - p0 != 1 || words_b.size() - n0 != 1) begin
            failures++;
            $display("FAIL par_bad: perr=%0d words=%0d required 1/1", pe_cnt_b - p0, words_b.size() - n0);
        end
        checks++;
        if (data_b !== 8'h07) begin
            failures++; $display("FAIL par_keep: got %h required 07", data_b);
        end
        send_bits(1, 12'h000, 4);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({data_b, valid_b, fe_b, pe_b, ov_b, busy_b} !== 13'd0) begin
            failures++; $display("FAIL mid_reset: got %h required 0", {data_b, valid_b, fe_b, pe_b, ov_b, busy_b});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (busy_b !== 1'b0) stayed_idle = 1'b0;
        end
        checks++;
        if (stayed_idle !== 1'b1) begin
            failures++; $display("FAIL low_after_reset: busy seen while line held low");
        end
        line_b = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        n0 = words_b.size();
        send_bits(1, frame8p(8'hC3, 1'b0, 1'b1), 11);
        repeat (20) @(negedge clk);
        checks++;
        if (words_b.size() - n0 != 1 || word_at(1, n0) !== 8'hC3) begin
            failures++;
            $display("FAIL post_reset: count=%0d word=%h required 1/c3", words_b.size() - n0, word_at(1, n0));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_parity_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
